// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with registered status flags, occupancy
// count, sticky overflow/underflow flags and a selectable read style.
//
// Parameters
//   DATA_W  data width (1..64)
//   DEPTH   entry count, power of two (4..1024)
//   AF_LVL  almost_full when count >= AF_LVL
//   AE_LVL  almost_empty when count <= AE_LVL
//   FWFT    0: data_r registered on accepted read, valid_r pulses one cycle
//           1: first-word-fall-through, data_r shows head, valid_r = !empty
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   en_w, data_w        write request and data
//   en_r                read request
//   clr_err             clears sticky ovf/unf
//   data_r, valid_r     read data and qualifier
//   full, empty, almost_full, almost_empty, count   occupancy status
//   ovf, unf            sticky overflow / underflow
module fifo_sync_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_w,
  input  logic [DATA_W-1:0]        data_w,
  input  logic                     en_r,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        data_r,
  output logic                     valid_r,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_ok, rd_ok;

  // Acceptance uses this cycle's registered flags, so a read on a full FIFO
  // does not make room for a same-cycle write.
  assign wr_ok = en_w && !full_q;
  assign rd_ok = en_r && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags are derived from the next count so they update on the same edge.
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AF_LVL));
    aempty_d = (count_d <= CW'(AE_LVL));

    // A new error wins over a simultaneous clear.
    ovf_d = clr_err ? 1'b0 : ovf_q;
    unf_d = clr_err ? 1'b0 : unf_q;
    if (en_w && full_q)  ovf_d = 1'b1;
    if (en_r && empty_q) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; writes are blocked during reset cycles.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem_q[wr_ptr_q] <= data_w;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] data_r_q;
      logic              valid_r_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_r_q  <= '0;
          valid_r_q <= 1'b0;
        end else begin
          valid_r_q <= rd_ok;
          if (rd_ok) data_r_q <= mem_q[rd_ptr_q];
        end
      end

      assign data_r  = data_r_q;
      assign valid_r = valid_r_q;
    end else begin : g_fwft
      assign data_r  = mem_q[rd_ptr_q];
      assign valid_r = !empty_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign ovf          = ovf_q;
  assign unf          = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed bench for fifo_sync_param (DATA_W=8, DEPTH=16,
// AF_LVL=14, AE_LVL=2). A standard-read instance (u_std) and a FWFT instance
// (u_fwft) share one stimulus stream.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n, en_w, en_r, clr_err;
  logic [7:0] data_w;

  logic [7:0] s_data_r, f_data_r;
  logic       s_valid, f_valid;
  logic       s_full, s_empty, s_af, s_ae;
  logic       f_full, f_empty, f_af, f_ae;
  logic [4:0] s_count, f_count;
  logic       s_ovf, s_unf, f_ovf, f_unf;

  int total = 0;
  int bad   = 0;
  int vpulses = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .en_w(en_w), .data_w(data_w), .en_r(en_r),
    .clr_err(clr_err), .data_r(s_data_r), .valid_r(s_valid), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .ovf(s_ovf), .unf(s_unf)
  );

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .en_w(en_w), .data_w(data_w), .en_r(en_r),
    .clr_err(clr_err), .data_r(f_data_r), .valid_r(f_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .ovf(f_ovf), .unf(f_unf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
    if (s_valid) vpulses++;
  endtask

  task automatic idle();
    en_w = 1'b0; en_r = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 64'(s_count), 64'd0);
    check({tag, "_empty"}, 64'(s_empty), 64'd1);
    check({tag, "_ae"},    64'(s_ae),    64'd1);
    check({tag, "_full"},  64'(s_full),  64'd0);
    check({tag, "_af"},    64'(s_af),    64'd0);
    check({tag, "_ovf"},   64'(s_ovf),   64'd0);
    check({tag, "_unf"},   64'(s_unf),   64'd0);
    check({tag, "_valid"}, 64'(s_valid), 64'd0);
    check({tag, "_data"},  64'(s_data_r), 64'd0);
    check({tag, "_fvalid"}, 64'(f_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; idle(); data_w = 8'h77;
    en_w = 1'b1;                       // must be ignored during reset
    step(); step();
    check_reset_state("rst");
    rst_n = 1'b1; idle();

    // FWFT head visible the cycle after a write to empty, no en_r needed
    en_w = 1'b1; data_w = 8'h5A; step(); idle();
    check("fwft_data", 64'(f_data_r), 64'h5A);
    check("fwft_valid", 64'(f_valid), 64'd1);
    check("std_novalid", 64'(s_valid), 64'd0);
    check("cnt_after_rst_wr", 64'(s_count), 64'd1);
    en_r = 1'b1; step(); idle();
    check("fwft_empty", 64'(f_empty), 64'd1);
    check("fwft_valid0", 64'(f_valid), 64'd0);
    check("std_rd_data", 64'(s_data_r), 64'h5A);
    check("std_rd_valid", 64'(s_valid), 64'd1);
    step();
    check("std_valid_pulse", 64'(s_valid), 64'd0);
    check("std_data_hold", 64'(s_data_r), 64'h5A);

    // Underflow on empty; count stays 0; clr_err clears
    en_r = 1'b1; step(); idle();
    check("unf_set", 64'(s_unf), 64'd1);
    check("unf_count", 64'(s_count), 64'd0);
    check("unf_novalid", 64'(s_valid), 64'd0);
    clr_err = 1'b1; step(); idle();
    check("unf_clr", 64'(s_unf), 64'd0);

    // Fill with 0x00..0x0F watching thresholds
    vpulses = 0;
    for (int i = 0; i < 16; i++) begin
      en_w = 1'b1; data_w = 8'(i); step(); idle();
      check("fill_count", 64'(s_count), 64'(i + 1));
      check("fill_ae", 64'(s_ae), 64'((i + 1) <= 2));
      check("fill_af", 64'(s_af), 64'((i + 1) >= 14));
      check("fill_full", 64'(s_full), 64'((i + 1) == 16));
    end

    // Overflow: write 0xAA to full is rejected
    en_w = 1'b1; data_w = 8'hAA; step(); idle();
    check("ovf_set", 64'(s_ovf), 64'd1);
    check("ovf_full", 64'(s_full), 64'd1);
    check("ovf_count", 64'(s_count), 64'd16);
    clr_err = 1'b1; step(); idle();
    check("ovf_clr", 64'(s_ovf), 64'd0);

    // Read+write at full: read accepted, write rejected, ovf set
    en_w = 1'b1; en_r = 1'b1; data_w = 8'hBB; step(); idle();
    check("rw_full_count", 64'(s_count), 64'd15);
    check("rw_full_data", 64'(s_data_r), 64'h00);
    check("rw_full_ovf", 64'(s_ovf), 64'd1);

    // Clear concurrent with a new overflow: flag stays
    en_w = 1'b1; data_w = 8'hAA; step(); idle();   // refills to 16
    check("refill_count", 64'(s_count), 64'd16);
    en_w = 1'b1; clr_err = 1'b1; data_w = 8'hAA; step(); idle();
    check("clr_vs_ovf", 64'(s_ovf), 64'd1);
    clr_err = 1'b1; step(); idle();
    check("ovf_clr2", 64'(s_ovf), 64'd0);

    // Drain: 0x01..0x0F then the refill word 0xAA (accepted earlier)
    for (int i = 1; i < 16; i++) begin
      en_r = 1'b1; step(); idle();
      check("drain_data", 64'(s_data_r), 64'(i));
      check("drain_valid", 64'(s_valid), 64'd1);
    end
    en_r = 1'b1; step(); idle();
    check("drain_last", 64'(s_data_r), 64'hAA);
    step();
    check("drain_empty", 64'(s_empty), 64'd1);
    check("drain_valid0", 64'(s_valid), 64'd0);
    check("valid_pulses", 64'(vpulses), 64'd17);

    // Count 8, then 20 simultaneous read/write cycles across the wrap
    for (int i = 0; i < 8; i++) begin
      en_w = 1'b1; data_w = 8'(8'h20 + i); step(); idle();
    end
    check("pre_wrap_count", 64'(s_count), 64'd8);
    for (int i = 0; i < 20; i++) begin
      en_w = 1'b1; en_r = 1'b1; data_w = 8'(8'h28 + i); step(); idle();
      check("wrap_data", 64'(s_data_r), 64'(8'h20 + i));
      check("wrap_count", 64'(s_count), 64'd8);
    end
    check("wrap_fwft_head", 64'(f_data_r), 64'h34);

    // Count 10, reset one cycle with en_w high
    en_w = 1'b1; data_w = 8'h50; step();
    data_w = 8'h51; step(); idle();
    check("pre_rst_count", 64'(s_count), 64'd10);
    rst_n = 1'b0; en_w = 1'b1; data_w = 8'hEE; step();
    rst_n = 1'b1; idle();
    check_reset_state("mid_rst");

    // First read after reset returns first post-reset write
    en_w = 1'b1; data_w = 8'h99; step(); idle();
    check("post_rst_fwft", 64'(f_data_r), 64'h99);
    en_r = 1'b1; step(); idle();
    check("post_rst_data", 64'(s_data_r), 64'h99);
    check("post_rst_empty", 64'(s_empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
